nand_seq_ctrl: RTL and testbench

NAND_SEQ_CTRL -- requirements
Module: nand_seq_ctrl

---
 rtl/nand_seq_ctrl.sv | 276 +++++++++++++++++++++++++++
 tb/tb_nand_seq_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nand_seq_ctrl.sv
// NAND flash operation sequencer: drives command/address/data bus cycles for READ, PROGRAM,
// ERASE and STATUS with programmable xWE/xRE low/high times and a ready/busy timeout.
module nand_seq_ctrl #(
  parameter int unsigned TWP  = 2,
  parameter int unsigned TWH  = 1,
  parameter int unsigned TOUT = 65535
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REQ,
  input  logic [1:0]  OP,
  input  logic [39:0] ADDR,
  input  logic [11:0] LEN,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  input  logic [7:0]  WR_DATA,
  input  logic        WR_VALID,
  output logic        WR_READY,
  output logic [7:0]  RD_DATA,
  output logic        RD_VALID,
  output logic [7:0]  IO_OUT,
  output logic        IO_OE,
  input  logic [7:0]  IO_IN,
  input  logic        RXB,
  output logic        ALE,
  output logic        CLE,
  output logic        xCE,
  output logic        xRE,
  output logic        xWE
);

  localparam int unsigned CW = $clog2(TWP + TWH + 2);
  localparam int unsigned WW = $clog2(TOUT + 2);
  localparam logic [CW-1:0] CycTwp    = CW'(TWP);
  localparam logic [CW-1:0] CycSample = CW'(TWP - 1);
  localparam logic [CW-1:0] CycLast   = CW'(TWP + TWH - 1);
  localparam logic [WW-1:0] WaitBlank = WW'(4);
  localparam logic [WW-1:0] WaitTout  = WW'(TOUT);

  localparam logic [1:0] OpRead  = 2'b00;
  localparam logic [1:0] OpProg  = 2'b01;
  localparam logic [1:0] OpErase = 2'b10;
  localparam logic [1:0] OpStat  = 2'b11;

  typedef enum logic [3:0] {
    StIdle, StCmd, StAddr, StWdata, StRdata, StWaitRb, StStatCmd, StStatRd, StFinish
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [39:0]   addr_q, addr_d;
  logic [11:0]   len_q, len_d;
  logic [11:0]   data_cnt_q, data_cnt_d;
  logic [2:0]    addr_cnt_q, addr_cnt_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          cmd2_q, cmd2_d;
  logic          err_q, err_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rxb_s1_q, rxb_s2_q;

  logic          hs, strobe_low, cyc_end, is_rd, bus_state;
  logic [CW-1:0] pos;
  logic [2:0]    addr_last;
  logic [7:0]    cmd_byte;

  // A data write cycle is prefixed by one handshake slot (cyc_q == 0) that stretches on stall.
  assign hs         = (state_q == StWdata) && (cyc_q == '0);
  assign pos        = (state_q == StWdata) ? cyc_q - CW'(1) : cyc_q;
  assign strobe_low = !hs && (pos < CycTwp);
  assign cyc_end    = !hs && (pos == CycLast);
  assign is_rd      = (state_q == StRdata) || (state_q == StStatRd);
  assign bus_state  = state_q inside {StCmd, StAddr, StWdata, StRdata, StStatCmd, StStatRd};
  assign addr_last  = (op_q == OpErase) ? 3'd2 : 3'd4;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      op_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      data_cnt_q <= '0;
      addr_cnt_q <= '0;
      cyc_q      <= '0;
      wait_q     <= '0;
      cmd2_q     <= 1'b0;
      err_q      <= 1'b0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rxb_s1_q   <= 1'b0;
      rxb_s2_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      data_cnt_q <= data_cnt_d;
      addr_cnt_q <= addr_cnt_d;
      cyc_q      <= cyc_d;
      wait_q     <= wait_d;
      cmd2_q     <= cmd2_d;
      err_q      <= err_d;
      wdata_q    <= wdata_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rxb_s1_q   <= RXB;
      rxb_s2_q   <= rxb_s1_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    len_d      = len_q;
    data_cnt_d = data_cnt_q;
    addr_cnt_d = addr_cnt_q;
    cyc_d      = cyc_q;
    wait_d     = wait_q;
    cmd2_d     = cmd2_q;
    err_d      = err_q;
    wdata_d    = wdata_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    if (bus_state) begin
      if (hs) begin
        if (WR_VALID) begin
          wdata_d = WR_DATA;
          cyc_d   = cyc_q + CW'(1);
        end
      end else if (cyc_end) begin
        cyc_d = '0;
      end else begin
        cyc_d = cyc_q + CW'(1);
      end
    end

    // Capture on the last low cycle; the pulse lands on the xRE rising cycle.
    if (is_rd && (pos == CycSample)) begin
      rd_data_d  = IO_IN;
      rd_valid_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (REQ) begin
          state_d    = StCmd;
          op_d       = OP;
          addr_d     = ADDR;
          len_d      = LEN;
          cmd2_d     = 1'b0;
          err_d      = 1'b0;
          addr_cnt_d = '0;
          data_cnt_d = '0;
          cyc_d      = '0;
        end
      end
      StCmd: begin
        if (cyc_end) begin
          if (cmd2_q) begin
            state_d = StWaitRb;
            wait_d  = '0;
          end else if (op_q == OpStat) begin
            state_d = StStatRd;
          end else begin
            state_d    = StAddr;
            addr_cnt_d = '0;
          end
        end
      end
      StAddr: begin
        if (cyc_end) begin
          if (addr_cnt_q == addr_last) begin
            addr_cnt_d = '0;
            data_cnt_d = '0;
            if ((op_q == OpProg) && (len_q != '0)) begin
              state_d = StWdata;
            end else begin
              state_d = StCmd;
              cmd2_d  = 1'b1;
            end
          end else begin
            addr_cnt_d = addr_cnt_q + 3'd1;
          end
        end
      end
      StWdata: begin
        if (cyc_end) begin
          if (data_cnt_q == len_q - 12'd1) begin
            state_d = StCmd;
            cmd2_d  = 1'b1;
          end else begin
            data_cnt_d = data_cnt_q + 12'd1;
          end
        end
      end
      StWaitRb: begin
        if ((wait_q >= WaitBlank) && rxb_s2_q) begin
          if (op_q != OpRead) begin
            state_d = StStatCmd;
          end else if (len_q == '0) begin
            state_d = StFinish;
          end else begin
            state_d    = StRdata;
            data_cnt_d = '0;
          end
        end else if (wait_q >= WaitTout) begin
          state_d = StFinish;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      StRdata: begin
        if (cyc_end) begin
          if (data_cnt_q == len_q - 12'd1) begin
            state_d = StFinish;
          end else begin
            data_cnt_d = data_cnt_q + 12'd1;
          end
        end
      end
      StStatCmd: begin
        if (cyc_end) state_d = StStatRd;
      end
      StStatRd: begin
        if (cyc_end) begin
          state_d = StFinish;
          err_d   = (op_q != OpStat) && rd_data_q[0];
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    case ({cmd2_q, op_q})
      {1'b0, OpRead}:  cmd_byte = 8'h00;
      {1'b0, OpProg}:  cmd_byte = 8'h80;
      {1'b0, OpErase}: cmd_byte = 8'h60;
      {1'b0, OpStat}:  cmd_byte = 8'h70;
      {1'b1, OpRead}:  cmd_byte = 8'h30;
      {1'b1, OpProg}:  cmd_byte = 8'h10;
      {1'b1, OpErase}: cmd_byte = 8'hD0;
      default:         cmd_byte = 8'h00;
    endcase

    BUSY     = (state_q != StIdle);
    DONE     = (state_q == StFinish);
    ERR      = (state_q == StFinish) && err_q;
    xCE      = (state_q == StIdle);
    CLE      = (state_q == StCmd) || (state_q == StStatCmd);
    ALE      = (state_q == StAddr);
    IO_OE    = state_q inside {StCmd, StAddr, StWdata, StStatCmd};
    xWE      = !(IO_OE && strobe_low);
    xRE      = !(is_rd && strobe_low);
    WR_READY = hs;
    RD_DATA  = rd_data_q;
    RD_VALID = rd_valid_q;

    case (state_q)
      StCmd:     IO_OUT = cmd_byte;
      StStatCmd: IO_OUT = 8'h70;
      StAddr:    IO_OUT = addr_q[{addr_cnt_q, 3'b000} +: 8];
      StWdata:   IO_OUT = wdata_q;
      default:   IO_OUT = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_nand_seq_ctrl.sv
// Directed bench for nand_seq_ctrl: a bus monitor logs write cycles, strobe widths and read
// pulses, and a small NAND model drives IO_IN and RXB.
module tb_nand_seq_ctrl;

  localparam int unsigned TWP  = 3;
  localparam int unsigned TWH  = 2;
  localparam int unsigned TOUT = 100;
  localparam logic [26:0] RstExp = {3'b111, 24'h000000};

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        REQ = 1'b0;
  logic [1:0]  OP = 2'b00;
  logic [39:0] ADDR = '0;
  logic [11:0] LEN = '0;
  logic        BUSY, DONE, ERR;
  logic [7:0]  WR_DATA = 8'h00;
  logic        WR_VALID = 1'b0;
  logic        WR_READY;
  logic [7:0]  RD_DATA;
  logic        RD_VALID;
  logic [7:0]  IO_OUT;
  logic        IO_OE;
  logic [7:0]  IO_IN;
  logic        RXB;
  logic        ALE, CLE, xCE, xRE, xWE;

  int n_checks = 0;
  int n_errs = 0;

  // Monitor / NAND model state
  logic [9:0] wlog[$];
  int         llog[$];
  int         hlog[$];
  logic [7:0] rlog[$];
  logic [9:0] exp_w[$];
  logic [9:0] cur = '0;
  logic       prev_we = 1'b1;
  logic       have_rise = 1'b0;
  logic       prev_busy = 1'b0;
  int         low_cnt = 0;
  int         high_cnt = 0;
  int         done_cnt = 0;
  logic       done_err = 1'b0;
  int         busy_rises = 0;
  int         ce_bad = 0;
  int         cyc_n = 0;
  int         conf_cyc = 0;
  int         done_cyc = 0;
  int         rel_rd = 0;
  logic       rxb_m = 1'b1;
  int         rb_cnt = 0;
  int         rb_busy = 5;
  logic       rb_stuck = 1'b0;
  logic [7:0] io_base = 8'h00;
  int         xre_rises = 0;
  int         xre_start = 0;

  assign RXB   = rxb_m;
  assign IO_IN = io_base + 8'(xre_rises - xre_start);

  nand_seq_ctrl #(.TWP(TWP), .TWH(TWH), .TOUT(TOUT)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .OP(OP), .ADDR(ADDR), .LEN(LEN),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .WR_DATA(WR_DATA), .WR_VALID(WR_VALID), .WR_READY(WR_READY),
    .RD_DATA(RD_DATA), .RD_VALID(RD_VALID),
    .IO_OUT(IO_OUT), .IO_OE(IO_OE), .IO_IN(IO_IN),
    .RXB(RXB), .ALE(ALE), .CLE(CLE), .xCE(xCE), .xRE(xRE), .xWE(xWE)
  );

  always #5 CLK = ~CLK;

  always @(posedge xRE) xre_rises++;

  always @(negedge CLK) begin
    cyc_n++;
    if (!RST_N) begin
      prev_we   = 1'b1;
      have_rise = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (rb_cnt > 0) begin
        rb_cnt--;
      end else if (!rb_stuck && !rxb_m) begin
        rxb_m  = 1'b1;
        rel_rd = rlog.size();
      end
      if (!xWE) begin
        if (prev_we) begin
          if (have_rise) hlog.push_back(high_cnt);
          low_cnt = 0;
        end
        low_cnt++;
        cur = {CLE, ALE, IO_OUT};
      end else begin
        if (!prev_we) begin
          wlog.push_back(cur);
          llog.push_back(low_cnt);
          have_rise = 1'b1;
          high_cnt  = 0;
          if (cur[9] && (cur[7:0] == 8'h30 || cur[7:0] == 8'h10 || cur[7:0] == 8'hD0)) begin
            rxb_m    = 1'b0;
            rb_cnt   = rb_busy;
            conf_cyc = cyc_n;
          end
        end
        high_cnt++;
      end
      prev_we = xWE;
      if (RD_VALID) rlog.push_back(RD_DATA);
      if (DONE) begin
        done_cnt++;
        done_err  = ERR;
        done_cyc  = cyc_n;
        have_rise = 1'b0;
      end
      if (BUSY && !prev_busy) busy_rises++;
      prev_busy = BUSY;
      if ((!xWE || !xRE) && xCE) ce_bad++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [26:0] outs();
    return {xCE, xWE, xRE, ALE, CLE, IO_OE, IO_OUT, BUSY, DONE, ERR, WR_READY, RD_VALID, RD_DATA};
  endfunction

  function automatic logic [9:0] cmd_w(input logic [7:0] b); return {2'b10, b}; endfunction
  function automatic logic [9:0] adr_w(input logic [7:0] b); return {2'b01, b}; endfunction
  function automatic logic [9:0] dat_w(input logic [7:0] b); return {2'b00, b}; endfunction

  function automatic logic [9:0] wr_at(input int i);
    if (i < wlog.size()) return wlog[i];
    return 10'hxxx;
  endfunction
  function automatic logic [7:0] rd_at(input int i);
    if (i < rlog.size()) return rlog[i];
    return 8'hxx;
  endfunction
  function automatic int hl_at(input int i);
    if (i < hlog.size()) return hlog[i];
    return -1;
  endfunction
  function automatic int ll_at(input int i);
    if (i < llog.size()) return llog[i];
    return -1;
  endfunction

  task automatic chk_wr(input string tag, input int base);
    chk({tag, "_cnt"}, 64'(wlog.size() - base), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size(); i++) chk({tag, "_byte"}, 64'(wr_at(base + i)), 64'(exp_w[i]));
  endtask

  task automatic start_op(input logic [1:0] op, input logic [39:0] addr, input logic [11:0] len);
    @(negedge CLK);
    OP = op; ADDR = addr; LEN = len; REQ = 1'b1;
    @(negedge CLK);
    REQ = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < max_cyc) begin
      @(posedge CLK);
      n++;
    end
    chk("done_seen", 64'(done_cnt != d0), 64'd1);
  endtask

  task automatic run_status(input string tag);
    int wb = wlog.size();
    int rb = rlog.size();
    io_base = 8'hE0;
    xre_start = xre_rises;
    exp_w.delete();
    exp_w.push_back(cmd_w(8'h70));
    start_op(2'b11, 40'h0, 12'd0);
    wait_done(200);
    chk({tag, "_err"}, 64'(done_err), 64'd0);
    chk_wr({tag, "_wr"}, wb);
    chk({tag, "_rd_cnt"}, 64'(rlog.size() - rb), 64'd1);
    chk({tag, "_rd_data"}, 64'(rd_at(rb)), 64'hE0);
    @(negedge CLK);
    chk({tag, "_ce_idle"}, 64'(xCE), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int wb, rb, hb, lb, bb, n, lows, lat;

    #2 RST_N = 1'b0;
    #1 chk("reset_outs", 64'(outs()), 64'(RstExp));
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;

    run_status("status");

    // READ with REQ held high: one start per IDLE entry
    wb = wlog.size(); rb = rlog.size(); hb = hlog.size(); lb = llog.size(); bb = busy_rises;
    io_base = 8'hA0; xre_start = xre_rises; rb_busy = 20;
    @(negedge CLK);
    OP = 2'b00; ADDR = 40'h04_03_02_01_00; LEN = 12'd3; REQ = 1'b1;
    wait_done(600);
    chk("read_one_start", 64'(busy_rises - bb), 64'd1);
    chk("read_err", 64'(done_err), 64'd0);
    exp_w.delete();
    exp_w.push_back(cmd_w(8'h00));
    for (int i = 0; i < 5; i++) exp_w.push_back(adr_w(8'(i)));
    exp_w.push_back(cmd_w(8'h30));
    chk_wr("read_wr", wb);
    chk("read_rd_cnt", 64'(rlog.size() - rb), 64'd3);
    chk("read_rd0", 64'(rd_at(rb)), 64'hA0);
    chk("read_rd1", 64'(rd_at(rb + 1)), 64'hA1);
    chk("read_rd2", 64'(rd_at(rb + 2)), 64'hA2);
    chk("read_rd_after_rb", 64'(rel_rd - rb), 64'd0);
    chk("twp_low", 64'(ll_at(lb)), 64'd3);
    chk("twh_high", 64'(hl_at(hb + 1)), 64'd2);

    n = 0;
    while (busy_rises - bb < 2 && n < 20) begin
      @(posedge CLK);
      n++;
    end
    chk("read_restart", 64'(busy_rises - bb), 64'd2);
    @(negedge CLK);
    REQ = 1'b0;
    n = 0;
    while (!ALE && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("read2_in_addr", 64'(ALE), 64'd1);
    #2 RST_N = 1'b0;
    #1 chk("midop_reset", 64'(outs()), 64'(RstExp));
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;

    run_status("post_rst");

    // PROGRAM, two bytes, second byte stalled
    wb = wlog.size(); rb = rlog.size(); hb = hlog.size();
    io_base = 8'h01; xre_start = xre_rises; rb_busy = 5;
    start_op(2'b01, 40'h12_34_56_78_90, 12'd2);
    WR_DATA = 8'h5A; WR_VALID = 1'b1;
    n = 0;
    @(negedge CLK);
    while (!WR_READY && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("prog_rdy1", 64'(WR_READY), 64'd1);
    @(negedge CLK);
    WR_VALID = 1'b0;
    n = 0;
    while (!WR_READY && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("prog_rdy2", 64'(WR_READY), 64'd1);
    lows = 0;
    repeat (10) begin
      @(negedge CLK);
      if (!xWE) lows++;
    end
    chk("prog_stall_we_high", 64'(lows), 64'd0);
    WR_DATA = 8'hA5; WR_VALID = 1'b1;
    @(negedge CLK);
    WR_VALID = 1'b0;
    wait_done(600);
    chk("prog_err", 64'(done_err), 64'd1);
    exp_w.delete();
    exp_w.push_back(cmd_w(8'h80));
    exp_w.push_back(adr_w(8'h90)); exp_w.push_back(adr_w(8'h78)); exp_w.push_back(adr_w(8'h56));
    exp_w.push_back(adr_w(8'h34)); exp_w.push_back(adr_w(8'h12));
    exp_w.push_back(dat_w(8'h5A)); exp_w.push_back(dat_w(8'hA5));
    exp_w.push_back(cmd_w(8'h10)); exp_w.push_back(cmd_w(8'h70));
    chk_wr("prog_wr", wb);
    chk("prog_rd_cnt", 64'(rlog.size() - rb), 64'd1);
    chk("prog_status", 64'(rd_at(rb)), 64'h01);
    chk("prog_stall_gap", 64'(hl_at(hb + 6) >= 10), 64'd1);

    // ERASE with RXB stuck low: timeout, no status command
    wb = wlog.size(); rb = rlog.size();
    rb_stuck = 1'b1;
    start_op(2'b10, 40'hFF_FF_33_22_11, 12'd0);
    wait_done(1000);
    chk("erase_err", 64'(done_err), 64'd1);
    exp_w.delete();
    exp_w.push_back(cmd_w(8'h60));
    exp_w.push_back(adr_w(8'h11)); exp_w.push_back(adr_w(8'h22)); exp_w.push_back(adr_w(8'h33));
    exp_w.push_back(cmd_w(8'hD0));
    chk_wr("erase_wr", wb);
    chk("erase_rd_cnt", 64'(rlog.size() - rb), 64'd0);
    lat = done_cyc - conf_cyc;
    chk("erase_timeout_lat", 64'(lat >= 95 && lat <= 110), 64'd1);
    rb_stuck = 1'b0;

    chk("ce_framing", 64'(ce_bad), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
